lc3_mem_arb: RTL and testbench

LC3_MEM_ARB -- requirements
Module: lc3_mem_arb

---
 rtl/lc3_mem_arb.sv | 108 ++++++++++
 tb/tb_lc3_mem_arb.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/lc3_mem_arb.sv
// lc3_mem_arb: round-robin arbiter sharing one LC-3 memory port among NCH requesters,
// with an optional wait-state timeout that aborts a stalled access.
module lc3_mem_arb #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int NCH     = 2,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
)(
  input  logic                  i_Clk,
  input  logic                  reset_,
  input  logic [NCH-1:0]        req,
  input  logic [NCH-1:0]        we,
  input  logic [NCH*ADDR_W-1:0] addr,
  input  logic [NCH*DATA_W-1:0] wdata,
  output logic [NCH-1:0]        gnt,
  output logic [NCH-1:0]        done,
  output logic [NCH-1:0]        err,
  output logic [DATA_W-1:0]     rdata,
  output logic                  mio_en,
  output logic                  rw,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  r
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3;
  localparam logic [TO_W-1:0] TLIM = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);
  logic [1:0] state;
  logic [CW-1:0] ptr, ch, sel, idx;
  logic armed, we_l, err_l, we_s, tmo;
  logic [ADDR_W-1:0] addr_l, addr_s;
  logic [DATA_W-1:0] wdata_l, wdata_s;
  logic [TO_W-1:0] cnt;
  // Scan from the farthest candidate down so the nearest requester after ptr wins.
  always_comb begin
    sel = ptr;
    idx = '0;
    for (int i = NCH; i >= 1; i--) begin
      idx = CW'((int'(ptr) + i) % NCH);
      if (req[idx]) sel = idx;
    end
  end
  always_comb begin
    we_s = 1'b0;
    addr_s = '0;
    wdata_s = '0;
    for (int k = 0; k < NCH; k++)
      if (sel == CW'(k)) begin
        we_s = we[k];
        addr_s = addr[k*ADDR_W +: ADDR_W];
        wdata_s = wdata[k*DATA_W +: DATA_W];
      end
  end
  assign gnt = (armed && state == IDLE && |req) ? NCH'(1) << sel : '0;
  assign mio_en = state == ISSUE || state == WAIT;
  assign rw = mio_en & we_l;
  assign mem_addr = mio_en ? addr_l : '0;
  assign mem_wdata = mio_en ? wdata_l : '0;
  assign done = (state == DONE) ? NCH'(1) << ch : '0;
  assign err = err_l ? done : '0;
  assign tmo = TIMEOUT != 0 && cnt == TLIM;
  // armed holds off the first grant until one full edge after reset release.
  always_ff @(posedge i_Clk or negedge reset_)
    if (!reset_) begin
      state <= IDLE;
      ptr <= CW'(NCH - 1);
      ch <= '0;
      armed <= 1'b0;
      we_l <= 1'b0;
      err_l <= 1'b0;
      addr_l <= '0;
      wdata_l <= '0;
      rdata <= '0;
      cnt <= '0;
    end else begin
      armed <= 1'b1;
      case (state)
        IDLE:
          if (armed && |req) begin
            state <= ISSUE;
            ptr <= sel;
            ch <= sel;
            we_l <= we_s;
            addr_l <= addr_s;
            wdata_l <= wdata_s;
          end
        ISSUE: begin
          cnt <= '0;
          state <= WAIT;
        end
        WAIT:
          if (r) begin
            if (!we_l) rdata <= mem_rdata;
            err_l <= 1'b0;
            state <= DONE;
          end else begin
            cnt <= (&cnt) ? cnt : cnt + 1'b1;
            if (tmo) begin
              err_l <= 1'b1;
              state <= DONE;
            end
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_lc3_mem_arb.sv
// tb_lc3_mem_arb: directed and randomized checks of lc3_mem_arb against a
// transaction-level model (grant, issue, counted waits, completion).
module tb_lc3_mem_arb;
  localparam int NCH = 2;
  localparam int TO = 4;
  logic i_Clk = 1'b0, reset_ = 1'b0;
  logic [1:0] req = '0, we = '0, gnt, done, err;
  logic [31:0] addr = '0, wdata = '0;
  logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata = '0;
  logic mio_en, rw, r = 1'b0;
  int n_cmp = 0, n_bad = 0;
  int m_stage, m_ch, m_last, m_waited;
  bit m_we, m_err, m_armed, last_err;
  logic [15:0] m_addr, m_wdata, m_rdata;
  int gq[$];

  lc3_mem_arb #(.DATA_W(16), .ADDR_W(16), .NCH(NCH), .TIMEOUT(TO), .TO_W(8)) dut (
    .i_Clk(i_Clk), .reset_(reset_), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .done(done), .err(err), .rdata(rdata), .mio_en(mio_en), .rw(rw),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .r(r)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got %0h want %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(logic [1:0] rq, int last);
    for (int k = 1; k <= NCH; k++) begin
      int c = (last + k) % NCH;
      if (rq[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_stage = 0;
    m_last = NCH - 1;
    m_rdata = '0;
    m_armed = 0;
    m_err = 0;
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic cycle();
    logic [1:0] e_gnt, e_done, e_err;
    logic e_en, e_rw;
    logic [15:0] e_a, e_wd;
    int pk;
    #1;
    e_gnt = '0; e_done = '0; e_err = '0; e_en = 0; e_rw = 0; e_a = '0; e_wd = '0; pk = -1;
    if (m_stage == 0 && m_armed) pk = pick(req, m_last);
    if (pk >= 0) e_gnt[pk] = 1'b1;
    if (m_stage == 1 || m_stage == 2) begin
      e_en = 1; e_rw = m_we; e_a = m_addr; e_wd = m_wdata;
    end
    if (m_stage == 3) begin
      e_done[m_ch] = 1'b1;
      e_err[m_ch] = m_err;
    end
    check("gnt", gnt, e_gnt);
    check("gnt_1hot", $countones(gnt) <= 1, 1);
    check("done", done, e_done);
    check("err", err, e_err);
    check("mio_en", mio_en, e_en);
    check("rw", rw, e_rw);
    check("mem_addr", mem_addr, e_a);
    check("mem_wdata", mem_wdata, e_wd);
    check("rdata", rdata, m_rdata);
    if (gnt != 0) gq.push_back(gnt[1] ? 1 : 0);
    if (done != 0) last_err = |err;
    m_armed = 1;
    case (m_stage)
      0: if (pk >= 0) begin
        m_ch = pk; m_last = pk; m_we = we[pk];
        m_addr = addr[pk*16 +: 16]; m_wdata = wdata[pk*16 +: 16];
        m_stage = 1;
      end
      1: begin m_waited = 0; m_stage = 2; end
      2: begin
        m_waited++;
        if (r) begin
          m_err = 0;
          if (!m_we) m_rdata = mem_rdata;
          m_stage = 3;
        end else if (TO != 0 && m_waited == TO) begin
          m_err = 1;
          m_stage = 3;
        end
      end
      default: m_stage = 0;
    endcase
    @(negedge i_Clk);
  endtask

  task automatic idle(int n);
    req = '0; r = 0;
    repeat (n) cycle();
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge i_Clk);
    reset_ = 1'b1;
    // single read, ready on the second WAIT cycle
    req = 2'b01; we = '0; addr = {16'h0, 16'h3000};
    cycle();
    cycle();
    req = '0; addr = '1;
    cycle();
    cycle();
    r = 1; mem_rdata = 16'hBEEF;
    cycle();
    r = 0; mem_rdata = '0;
    cycle();
    idle(2);
    check("read_rdata", rdata, 16'hBEEF);
    // write on channel 1; inputs scrambled after grant
    req = 2'b10; we = 2'b10; addr = {16'h4010, 16'h0}; wdata = {16'h1234, 16'h0};
    cycle();
    req = '0; we = '0; addr = '1; wdata = '1; mem_rdata = 16'h7777;
    cycle();
    r = 1;
    cycle();
    r = 0;
    cycle();
    idle(2);
    check("write_rdata", rdata, 16'hBEEF);
    // contention with both requesters held
    gq.delete();
    req = 2'b11; r = 1; mem_rdata = 16'hCAFE; addr = '0;
    repeat (20) cycle();
    idle(3);
    check("cont_count", gq.size() >= 4, 1);
    if (gq.size() >= 4) begin
      check("cont_g0", gq[0], 0);
      check("cont_g1", gq[1], 1);
      check("cont_g2", gq[2], 0);
      check("cont_g3", gq[3], 1);
    end
    // timeout with r held low
    req = 2'b01; mem_rdata = 16'h1111;
    cycle();
    req = '0;
    repeat (7) cycle();
    idle(2);
    check("to_err", last_err, 1);
    check("to_rdata", rdata, 16'hCAFE);
    // ready on the last WAIT cycle beats the timeout
    req = 2'b01; mem_rdata = 16'h5A5A;
    cycle();
    req = '0;
    repeat (4) cycle();
    r = 1;
    cycle();
    r = 0;
    cycle();
    idle(2);
    check("late_r_err", last_err, 0);
    check("late_r_rdata", rdata, 16'h5A5A);
    // reset pulsed mid-WAIT
    req = 2'b10;
    cycle();
    req = '0;
    cycle();
    cycle();
    #2 reset_ = 1'b0;
    #1;
    check("rst_mio_en", mio_en, 0);
    check("rst_done", done, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_rdata", rdata, 0);
    model_reset();
    req = 2'b11; r = 1;
    @(negedge i_Clk);
    reset_ = 1'b1;
    gq.delete();
    repeat (3) cycle();
    check("rst_first_gnt", gq.size() >= 1 && gq[0] == 0, 1);
    idle(4);
    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      req = 2'($urandom);
      we = 2'($urandom);
      addr = $urandom;
      wdata = $urandom;
      mem_rdata = 16'($urandom);
      r = $urandom_range(0, 3) == 0;
      cycle();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
